// File: rtl/mmr_counter_bank.sv
// mmr_counter_bank: a bank of N_CHANNELS counters. Each counter is stored as
// K_MMR replicas. Every replica reloads from the bitwise-majority value, so a
// single upset replica is repaired on the next clock edge.
// mismatch_o pulses for one cycle after any cycle in which the replicated
// inputs or the stored replicas disagree.
// Optional feature: define MMR_COUNTER_SNAPSHOT_EN to add per-channel snapshot
// registers. Without it, snapshot_value_o simply mirrors voted_value_o and
// snapshot_i is ignored.
module mmr_counter_bank #(
  parameter int K_MMR         = 3,
  parameter int N_CHANNELS    = 4,
  parameter int BIT_WIDTH     = 16,
  parameter int IS_SATURATING = 0,
  parameter int MISMATCH_EN   = 1
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [K_MMR-1:0]                                 reset_counter_i,
  input  logic [N_CHANNELS-1:0][K_MMR-1:0]                 countup_i,
  input  logic [K_MMR-1:0]                                 snapshot_i,
  output logic [N_CHANNELS-1:0][K_MMR-1:0][BIT_WIDTH-1:0]  counter_value_o,
  output logic [N_CHANNELS-1:0][BIT_WIDTH-1:0]             voted_value_o,
  output logic [N_CHANNELS-1:0][BIT_WIDTH-1:0]             snapshot_value_o,
  output logic [N_CHANNELS-1:0]                            overflow_o,
  output logic                                             mismatch_o
);

  // Majority threshold: 2 of 3, or 3 of 5.
  localparam int THRESH = K_MMR / 2 + 1;
  localparam logic [BIT_WIDTH-1:0] MAX_VAL = '1;

  logic [N_CHANNELS-1:0][K_MMR-1:0][BIT_WIDTH-1:0] cnt_q;
  logic [N_CHANNELS-1:0][BIT_WIDTH-1:0]            next_val;
  logic [N_CHANNELS-1:0]                           ovf_q;
  logic [N_CHANNELS-1:0]                           next_ovf;
  logic                                            mismatch_q;
  logic                                            any_dis;
  logic                                            snap_dis;
  logic                                            rc_v;

  // Majority vote over one replicated bit.
  function automatic logic vote_bit(input logic [K_MMR-1:0] v);
    int ones;
    ones = 0;
    for (int k = 0; k < K_MMR; k++) ones += int'(v[k]);
    return (ones >= THRESH);
  endfunction

  // A replicated strobe disagrees when it is neither all-zero nor all-one.
  function automatic logic disagree(input logic [K_MMR-1:0] v);
    return (v != '0) && (v != '1);
  endfunction

  // Bitwise majority of all replicas of one counter word.
  function automatic logic [BIT_WIDTH-1:0] vote_word(
    input logic [K_MMR-1:0][BIT_WIDTH-1:0] w
  );
    logic [BIT_WIDTH-1:0] r;
    logic [K_MMR-1:0]     col;
    r   = '0;
    col = '0;
    for (int b = 0; b < BIT_WIDTH; b++) begin
      for (int k = 0; k < K_MMR; k++) col[k] = w[k][b];
      r[b] = vote_bit(col);
    end
    return r;
  endfunction

  // True when any replica of a word differs from replica 0.
  function automatic logic word_disagree(
    input logic [K_MMR-1:0][BIT_WIDTH-1:0] w
  );
    logic d;
    d = 1'b0;
    for (int k = 1; k < K_MMR; k++) d |= (w[k] != w[0]);
    return d;
  endfunction

  assign counter_value_o = cnt_q;
  assign overflow_o      = ovf_q;
  assign mismatch_o      = mismatch_q;

  // Voted counter value, taken straight from the replica outputs.
  always_comb begin
    voted_value_o = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      voted_value_o[c] = vote_word(counter_value_o[c]);
    end
  end

  // Next value and overflow per channel from voted state and voted strobes;
  // the clear wins over an increment in the same cycle.
  always_comb begin
    next_val = voted_value_o;
    next_ovf = ovf_q;
    rc_v     = vote_bit(reset_counter_i);
    any_dis  = disagree(reset_counter_i) | snap_dis;
    for (int c = 0; c < N_CHANNELS; c++) begin
      any_dis = any_dis | disagree(countup_i[c]) | word_disagree(counter_value_o[c]);
      if (rc_v) begin
        next_val[c] = '0;
        next_ovf[c] = 1'b0;
      end else if (vote_bit(countup_i[c])) begin
        if (voted_value_o[c] == MAX_VAL) begin
          next_val[c] = (IS_SATURATING != 0) ? MAX_VAL : '0;
          next_ovf[c] = 1'b1;
        end else begin
          next_val[c] = voted_value_o[c] + 1'b1;
        end
      end
    end
  end

  // Every replica of a channel loads the same voted next value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= '0;
    end else begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        for (int k = 0; k < K_MMR; k++) cnt_q[c][k] <= next_val[c];
      end
      ovf_q <= next_ovf;
    end
  end

  // One-cycle disagreement flag, recomputed every cycle so it never sticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mismatch_q <= 1'b0;
    else     mismatch_q <= (MISMATCH_EN != 0) ? any_dis : 1'b0;
  end

`ifdef MMR_COUNTER_SNAPSHOT_EN
  logic [N_CHANNELS-1:0][BIT_WIDTH-1:0] snap_q;

  assign snapshot_value_o = snap_q;
  assign snap_dis         = disagree(snapshot_i);

  // Capture the voted value as it stood before this edge's update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         snap_q <= '0;
    else if (vote_bit(snapshot_i))   snap_q <= voted_value_o;
  end
`else
  logic unused_snapshot;

  assign unused_snapshot  = ^snapshot_i;
  assign snapshot_value_o = voted_value_o;
  assign snap_dis         = 1'b0;
`endif

endmodule

// File: tb/tb_mmr_counter_bank.sv
// tb_mmr_counter_bank: two 4-bit, 4-channel, 3-replica banks sharing inputs,
// one wrapping and one saturating, checked every cycle against a
// behavioural model plus hand-computed scenario expectations.
module tb_mmr_counter_bank;
  localparam int K    = 3;
  localparam int N    = 4;
  localparam int W    = 4;
  localparam int MAXV = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [K-1:0]                reset_counter;
  logic [N-1:0][K-1:0]         countup;
  logic [K-1:0]                snapshot;
  logic [N-1:0][K-1:0][W-1:0]  cnt0, cnt1, upset_vec;
  logic [N-1:0][W-1:0]         vot0, vot1, snp0, snp1;
  logic [N-1:0]                ovf0, ovf1;
  logic                        mm0, mm1;
  logic                        upset;

  int checks = 0;
  int errors = 0;

  mmr_counter_bank #(.K_MMR(K), .N_CHANNELS(N), .BIT_WIDTH(W),
                     .IS_SATURATING(0), .MISMATCH_EN(1)) dut0 (
    .clk(clk), .rst(rst), .reset_counter_i(reset_counter), .countup_i(countup),
    .snapshot_i(snapshot), .counter_value_o(cnt0), .voted_value_o(vot0),
    .snapshot_value_o(snp0), .overflow_o(ovf0), .mismatch_o(mm0));

  mmr_counter_bank #(.K_MMR(K), .N_CHANNELS(N), .BIT_WIDTH(W),
                     .IS_SATURATING(1), .MISMATCH_EN(1)) dut1 (
    .clk(clk), .rst(rst), .reset_counter_i(reset_counter), .countup_i(countup),
    .snapshot_i(snapshot), .counter_value_o(cnt1), .voted_value_o(vot1),
    .snapshot_value_o(snp1), .overflow_o(ovf1), .mismatch_o(mm1));

  // ---------------- behavioural model ----------------
  int m_val  [2][N];
  int m_snap [2][N];
  bit m_ovf  [2][N];
  bit m_mm   [2];

  function automatic bit maj(input logic [K-1:0] v);
    return $countones(v) >= 2;
  endfunction

  function automatic bit split(input logic [K-1:0] v);
    return (v != 3'b000) && (v != 3'b111);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < N; c++) begin
          m_val[d][c]  <= 0;
          m_snap[d][c] <= 0;
          m_ovf[d][c]  <= 1'b0;
        end
        m_mm[d] <= 1'b0;
      end
    end else begin
      bit rc, sn, dis;
      rc  = maj(reset_counter);
      sn  = maj(snapshot);
      dis = split(reset_counter);
      for (int c = 0; c < N; c++) dis |= split(countup[c]);
`ifdef MMR_COUNTER_SNAPSHOT_EN
      dis |= split(snapshot);
`endif
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < N; c++) begin
          if (sn) m_snap[d][c] <= m_val[d][c];
          if (rc) begin
            m_val[d][c] <= 0;
            m_ovf[d][c] <= 1'b0;
          end else if (maj(countup[c])) begin
            if (m_val[d][c] == MAXV) begin
              m_val[d][c] <= (d == 1) ? MAXV : 0;
              m_ovf[d][c] <= 1'b1;
            end else begin
              m_val[d][c] <= m_val[d][c] + 1;
            end
          end
        end
      end
      m_mm[0] <= dis | upset;
      m_mm[1] <= dis;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_dut(input int d, input logic [N-1:0][W-1:0] vot,
                             input logic [N-1:0][K-1:0][W-1:0] cnt,
                             input logic [N-1:0][W-1:0] snp,
                             input logic [N-1:0] ovf, input logic mm);
    for (int c = 0; c < N; c++) begin
      check($sformatf("dut%0d ch%0d voted", d, c), vot[c], m_val[d][c]);
      for (int k = 0; k < K; k++)
        check($sformatf("dut%0d ch%0d replica%0d", d, c, k), cnt[c][k], m_val[d][c]);
      check($sformatf("dut%0d ch%0d overflow", d, c), ovf[c], m_ovf[d][c]);
`ifdef MMR_COUNTER_SNAPSHOT_EN
      check($sformatf("dut%0d ch%0d snapshot", d, c), snp[c], m_snap[d][c]);
`else
      check($sformatf("dut%0d ch%0d snapshot", d, c), snp[c], m_val[d][c]);
`endif
    end
    check($sformatf("dut%0d mismatch", d), mm, m_mm[d]);
  endtask

  // Compare both banks against the model on every falling edge.
  always @(negedge clk) begin
    compare_dut(0, vot0, cnt0, snp0, ovf0, mm0);
    compare_dut(1, vot1, cnt1, snp1, ovf1, mm1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    reset_counter = '0;
    countup       = '0;
    snapshot      = '0;
  endtask

  task automatic clear_all();
    reset_counter = '1;
    tick();
    reset_counter = '0;
  endtask

  task automatic count_ch(input int c, input int n);
    countup    = '0;
    countup[c] = 3'b111;
    repeat (n) tick();
    countup    = '0;
  endtask

  function automatic logic [K-1:0] rep3(input bit b);
    logic [K-1:0] v;
    v = b ? 3'b111 : 3'b000;
    if ($urandom_range(0, 9) == 0) v[$urandom_range(0, 2)] = ~v[$urandom_range(0, 2)];
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b1;
    upset = 1'b0;
    idle();
    repeat (2) tick();
    check("reset voted", vot0[0], 0);
    check("reset overflow", ovf0, 0);
    check("reset mismatch", mm0, 0);
    rst = 1'b0;

    // basic count
    count_ch(0, 5);
    check("basic count", vot0[0], 5);
    check("basic mismatch", mm0, 0);

    // wrap / saturate
    clear_all();
    count_ch(0, 16);
    check("wrap value", vot0[0], 0);
    check("wrap overflow", ovf0[0], 1);
    check("sat value", vot1[0], 15);
    check("sat overflow", ovf1[0], 1);
    count_ch(0, 1);
    check("sat hold 17th", vot1[0], 15);
    check("wrap 17th", vot0[0], 1);
    check("overflow sticky", ovf0[0], 1);
    clear_all();
    check("clear overflow", ovf0[0], 0);
    check("clear value", vot1[0], 0);

    // input disagreement
    countup[2] = 3'b001;
    tick();
    check("minority countup value", vot0[2], 0);
    check("minority countup mismatch", mm0, 1);
    countup[2] = 3'b011;
    tick();
    check("majority countup value", vot0[2], 1);
    check("majority countup mismatch", mm0, 1);
    countup = '0;
    tick();
    check("mismatch not sticky", mm0, 0);

    // single-replica upset on dut0 channel 1 replica 2
    count_ch(1, 3);
    upset_vec       = cnt0;
    upset_vec[1][2] = upset_vec[1][2] ^ 4'b0001;
    force dut0.counter_value_o = upset_vec;
    upset = 1'b1;
    @(posedge clk);
    #1;
    release dut0.counter_value_o;
    upset = 1'b0;
    @(negedge clk);
    #1;
    check("upset mismatch", mm0, 1);
    check("upset repaired", cnt0[1][2], 3);
    check("upset voted", vot0[1], 3);
    tick();
    check("upset mismatch clears", mm0, 0);

    // collision: clear + countup (+ snapshot) at value 7
    clear_all();
    count_ch(0, 16);
    countup = '1;
    repeat (7) tick();
    countup = '0;
    check("pre-collision value", vot0[3], 7);
    check("pre-collision overflow", ovf0[0], 1);
    reset_counter = '1;
    countup       = '1;
    snapshot      = '1;
    tick();
    idle();
    for (int c = 0; c < N; c++) check($sformatf("collision ch%0d", c), vot0[c], 0);
    check("collision overflow", ovf0[0], 0);
`ifdef MMR_COUNTER_SNAPSHOT_EN
    check("collision snapshot", snp0[0], 7);
`else
    check("collision snapshot", snp0[0], 0);
`endif

    // asynchronous reset between edges at count 9
    count_ch(0, 9);
    check("pre-async value", vot0[0], 9);
    rst = 1'b1;
    #1;
    check("async voted", vot0[0], 0);
    check("async replica", cnt0[0][1], 0);
    check("async snapshot", snp0[0], 0);
    check("async mismatch", mm0, 0);
    countup[0] = 3'b111;
    #1;
    rst = 1'b0;
    tick();
    countup = '0;
    check("first count after reset", vot0[0], 1);
    check("no mismatch on release", mm0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset_counter = rep3($urandom_range(0, 19) == 0);
      for (int c = 0; c < N; c++) countup[c] = rep3($urandom_range(0, 1) == 1);
      snapshot = rep3($urandom_range(0, 7) == 0);
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the run must never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
